// File: rtl/bayes_pkg.sv
// rtl/bayes_pkg.sv - shared state type and constants for the Bayesian inference sequencer
package bayes_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEED,
    ST_OBS_ADDR,
    ST_OBS_PRE,
    ST_OBS_PULSE,
    ST_OBS_LATCH,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } infer_state_t;

  localparam int NUM_CLASS     = 4;
  localparam int OBS_PULSE_CYC = 2;

  // Observation word: column select in the low bits, likelihood row above it.
  localparam int OBS_W       = 9;
  localparam int OBS_COL_LSB = 0;
  localparam int OBS_COL_W   = 3;
  localparam int OBS_ROW_LSB = 3;
  localparam int OBS_ROW_W   = 6;

endpackage

// File: rtl/bayes_class_counter.sv
// rtl/bayes_class_counter.sv - saturating per-class ones counter with synchronous clear
module bayes_class_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] value,
  output logic [CNT_W-1:0] value_next
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // value_next is exported so the argmax can see the final sample in the same cycle.
  always_comb begin
    value_next = value;
    if (clr) begin
      value_next = '0;
    end else if (inc && (value != CNT_MAX)) begin
      value_next = value + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else begin
      value <= value_next;
    end
  end

endmodule

// File: rtl/bayes_infer_seq.sv
// rtl/bayes_infer_seq.sv - start-triggered seed/observe/run sequencer with per-class counts and argmax
module bayes_infer_seq
  import bayes_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int CYC_W = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [NUM_CLASS-1:0][OBS_W-1:0]      cfg_obs,
  input  logic [7:0]                           cfg_seed,
  input  logic [CYC_W-1:0]                     cfg_cycles,
  input  logic                                 cfg_stoch_log,
  output logic                                 busy,
  output logic                                 done,
  output logic [NUM_CLASS-1:0][CNT_W-1:0]      count,
  output logic [1:0]                           winner,
  output logic                                 CBL,
  output logic                                 CBLEN,
  output logic                                 CSL,
  output logic                                 CWL,
  output logic                                 inference,
  output logic                                 load_seed,
  output logic                                 read_1,
  output logic                                 read_8,
  output logic                                 load_mem,
  output logic                                 read_out,
  output logic                                 stoch_log,
  output logic [7:0]                           adr_full_col,
  output logic [7:0]                           adr_full_row,
  output logic [7:0]                           seeds,
  input  logic [NUM_CLASS-1:0]                 bit_out
);

  localparam logic [CYC_W-1:0] CYC_ONE    = {{(CYC_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]       PULSE_LAST = 2'(OBS_PULSE_CYC - 1);

  infer_state_t                      state, state_next;
  logic [NUM_CLASS-1:0][OBS_W-1:0]   obs_sh;
  logic [7:0]                        seed_sh;
  logic [CYC_W-1:0]                  cycles_sh;
  logic                              sl_sh;
  logic [1:0]                        k;
  logic [1:0]                        pcnt;
  logic [CYC_W-1:0]                  cyc;
  logic                              run_d;
  logic                              accept;
  logic [NUM_CLASS-1:0][CNT_W-1:0]   cnt_next;
  logic [OBS_W-1:0]                  obs_sel;
  logic [1:0]                        w01, w23, win_next;
  logic [CNT_W-1:0]                  v01, v23;

  assign accept  = (state == ST_IDLE) && start;
  assign obs_sel = obs_sh[k];

  always_comb begin
    state_next   = state;
    busy         = (state != ST_IDLE);
    done         = 1'b0;
    CBL          = 1'b0;
    CBLEN        = 1'b0;
    CSL          = 1'b0;
    CWL          = 1'b0;
    inference    = 1'b0;
    load_seed    = 1'b0;
    read_1       = 1'b0;
    read_8       = 1'b0;
    load_mem     = 1'b0;
    read_out     = 1'b0;
    stoch_log    = 1'b0;
    adr_full_col = 8'h00;
    adr_full_row = 8'h00;
    seeds        = 8'h00;
    case (state)
      ST_IDLE: if (start) state_next = ST_SEED;
      ST_SEED: begin
        load_seed  = 1'b1;
        seeds      = seed_sh;
        state_next = ST_OBS_ADDR;
      end
      ST_OBS_ADDR: state_next = ST_OBS_PRE;
      ST_OBS_PRE: begin
        CSL        = 1'b1;
        CWL        = 1'b1;
        read_8     = 1'b1;
        stoch_log  = 1'b1;
        state_next = ST_OBS_PULSE;
      end
      ST_OBS_PULSE: begin
        CWL       = 1'b1;
        read_8    = 1'b1;
        stoch_log = 1'b1;
        if (pcnt == PULSE_LAST) state_next = ST_OBS_LATCH;
      end
      ST_OBS_LATCH: begin
        inference = 1'b1;
        read_8    = 1'b1;
        if (k == 2'd3) state_next = (cycles_sh == '0) ? ST_DONE : ST_RUN;
        else           state_next = ST_OBS_ADDR;
      end
      ST_RUN: begin
        inference = 1'b1;
        read_1    = 1'b1;
        stoch_log = sl_sh;
        if (cyc == '0) state_next = ST_DRAIN;
      end
      ST_DRAIN: state_next = ST_DONE;
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // The observation address stays up for the whole five-cycle access.
    if (state inside {ST_OBS_ADDR, ST_OBS_PRE, ST_OBS_PULSE, ST_OBS_LATCH}) begin
      adr_full_col = {k, 3'b000, obs_sel[OBS_COL_LSB +: OBS_COL_W]};
      adr_full_row = {2'b00, obs_sel[OBS_ROW_LSB +: OBS_ROW_W]};
    end
  end

  // Tie-break favours the lower index at both levels of the tree.
  always_comb begin
    w01      = (cnt_next[1] > cnt_next[0]) ? 2'd1 : 2'd0;
    v01      = (cnt_next[1] > cnt_next[0]) ? cnt_next[1] : cnt_next[0];
    w23      = (cnt_next[3] > cnt_next[2]) ? 2'd3 : 2'd2;
    v23      = (cnt_next[3] > cnt_next[2]) ? cnt_next[3] : cnt_next[2];
    win_next = (v23 > v01) ? w23 : w01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      obs_sh    <= '0;
      seed_sh   <= '0;
      cycles_sh <= '0;
      sl_sh     <= 1'b0;
      k         <= '0;
      pcnt      <= '0;
      cyc       <= '0;
      run_d     <= 1'b0;
      winner    <= '0;
    end else begin
      state <= state_next;
      run_d <= (state == ST_RUN);
      case (state)
        ST_IDLE: if (start) begin
          obs_sh    <= cfg_obs;
          seed_sh   <= cfg_seed;
          cycles_sh <= cfg_cycles;
          sl_sh     <= cfg_stoch_log;
          k         <= '0;
          winner    <= '0;
        end
        ST_OBS_ADDR:  pcnt <= '0;
        ST_OBS_PULSE: pcnt <= pcnt + 2'd1;
        ST_OBS_LATCH: begin
          k   <= k + 2'd1;
          cyc <= cycles_sh - CYC_ONE;
        end
        ST_RUN:   cyc    <= cyc - CYC_ONE;
        ST_DRAIN: winner <= win_next;
        default: ;
      endcase
    end
  end

  // bit_out answers the previous RUN cycle, so sampling is gated by the delayed RUN flag.
  for (genvar c = 0; c < NUM_CLASS; c++) begin : g_cnt
    bayes_class_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .clr        (accept),
      .inc        (run_d & bit_out[c]),
      .value      (count[c]),
      .value_next (cnt_next[c])
    );
  end

endmodule

// File: tb/tb_bayes_infer_seq.sv
// tb/tb_bayes_infer_seq.sv - scoreboard bench for the inference sequencer
module tb_bayes_infer_seq;

  localparam int CNT_W = 4;
  localparam int CYC_W = 16;

  logic                  clk = 1'b0;
  logic                  rst, start, cfg_stoch_log;
  logic [3:0][8:0]       cfg_obs;
  logic [7:0]            cfg_seed;
  logic [CYC_W-1:0]      cfg_cycles;
  logic                  busy, done;
  logic [3:0][CNT_W-1:0] count;
  logic [1:0]            winner;
  logic CBL, CBLEN, CSL, CWL, inference, load_seed, read_1, read_8, load_mem, read_out, stoch_log;
  logic [7:0]            adr_full_col, adr_full_row, seeds;
  logic [3:0]            bit_out;
  logic [36:0]           pins;

  bayes_infer_seq #(.CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_obs(cfg_obs), .cfg_seed(cfg_seed),
    .cfg_cycles(cfg_cycles), .cfg_stoch_log(cfg_stoch_log), .busy(busy), .done(done),
    .count(count), .winner(winner), .CBL(CBL), .CBLEN(CBLEN), .CSL(CSL), .CWL(CWL),
    .inference(inference), .load_seed(load_seed), .read_1(read_1), .read_8(read_8),
    .load_mem(load_mem), .read_out(read_out), .stoch_log(stoch_log),
    .adr_full_col(adr_full_col), .adr_full_row(adr_full_row), .seeds(seeds), .bit_out(bit_out)
  );

  assign pins = {busy, done, CBL, CBLEN, CSL, CWL, inference, load_seed, read_1, read_8,
                 load_mem, read_out, stoch_log, adr_full_col, adr_full_row, seeds};

  typedef struct {
    logic [15:0] cnt;
    logic [1:0]  win;
    int          lat;
    int          t0;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         n_done = 0;
  logic [3:0] pat [0:7];
  int         pat_len = 1;
  int         samp_idx = 0;
  logic       was_run = 1'b0;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Array model: answers each RUN cycle one cycle later; all-ones elsewhere.
  initial begin
    bit_out = 4'h0;
    forever begin
      @(negedge clk);
      if (was_run) begin
        bit_out = pat[samp_idx % pat_len];
        samp_idx++;
      end else begin
        bit_out = 4'hF;
      end
      was_run = inference & read_1;
      if (!busy) samp_idx = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int n, input int t0);
    exp_t       e;
    logic [3:0] c [4];
    logic [3:0] s;
    int         w;
    for (int j = 0; j < 4; j++) c[j] = 4'h0;
    for (int i = 0; i < n; i++) begin
      s = pat[i % pat_len];
      for (int j = 0; j < 4; j++) if (s[j] && c[j] != 4'hF) c[j] = c[j] + 4'h1;
    end
    w = 0;
    for (int j = 1; j < 4; j++) if (c[j] > c[w]) w = j;
    e.cnt = {c[3], c[2], c[1], c[0]};
    e.win = 2'(w);
    e.lat = (n == 0) ? 22 : n + 23;
    e.t0  = t0;
    return e;
  endfunction

  function automatic logic [36:0] exp_pins(input int o, input int n, input logic [3:0][8:0] obs,
                                           input logic [7:0] seed, input logic sl);
    logic       bsy, dn, csl, cwl, inf, lsd, r1, r8, slo;
    logic [7:0] col, row, sd;
    logic [8:0] ob;
    int         last, k, p;
    {bsy, dn, csl, cwl, inf, lsd, r1, r8, slo} = '0;
    col  = 8'h00;
    row  = 8'h00;
    sd   = 8'h00;
    last = (n == 0) ? 22 : n + 23;
    if (o >= 1 && o <= last) bsy = 1'b1;
    if (o == last) dn = 1'b1;
    if (o == 1) begin
      lsd = 1'b1;
      sd  = seed;
    end else if (o >= 2 && o <= 21) begin
      k   = (o - 2) / 5;
      p   = (o - 2) % 5;
      ob  = obs[k];
      col = {k[1:0], 3'b000, ob[2:0]};
      row = {2'b00, ob[8:3]};
      case (p)
        1:       {csl, cwl, r8, slo} = 4'b1111;
        2, 3:    {cwl, r8, slo} = 3'b111;
        4:       {inf, r8} = 2'b11;
        default: ;
      endcase
    end else if (n > 0 && o >= 22 && o <= 21 + n) begin
      inf = 1'b1;
      r1  = 1'b1;
      slo = sl;
    end
    return {bsy, dn, 1'b0, 1'b0, csl, cwl, inf, lsd, r1, r8, 1'b0, 1'b0, slo, col, row, sd};
  endfunction

  // poke_kind 1: raise start and scramble cfg at offset poke_o; 2: reset at offset poke_o.
  task automatic run(input logic [3:0][8:0] obs, input logic [7:0] seed, input int n,
                     input logic sl, input int poke_o, input int poke_kind);
    exp_t e, got_e;
    int   t0, done0;
    @(negedge clk);
    cfg_obs       = obs;
    cfg_seed      = seed;
    cfg_cycles    = CYC_W'(n);
    cfg_stoch_log = sl;
    start         = 1'b1;
    t0            = cyc;
    e             = model(n, t0);
    sb.push_back(e);
    done0         = n_done;
    for (int o = 1; o <= e.lat + 1; o++) begin
      @(negedge clk);
      start = 1'b0;
      check("pins", pins, exp_pins(o, n, obs, seed, sl));
      if (done) begin
        n_done++;
        if (sb.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          got_e = sb.pop_front();
          check("count", count, got_e.cnt);
          check("winner", winner, got_e.win);
          check("latency", cyc - got_e.t0, got_e.lat);
        end
      end
      if (o == poke_o && poke_kind == 1) begin
        start         = 1'b1;
        cfg_cycles    = CYC_W'(3);
        cfg_obs       = '0;
        cfg_seed      = 8'h00;
        cfg_stoch_log = ~sl;
      end
      if (o == poke_o && poke_kind == 2) begin
        rst = 1'b1;
        @(negedge clk);
        check("rst_pins", pins, 0);
        check("rst_count", count, 0);
        check("rst_winner", winner, 0);
        rst = 1'b0;
        sb.delete();
        return;
      end
    end
    check("done_cnt", n_done - done0, 1);
    check("sb_empty", sb.size(), 0);
    sb.delete();
    @(negedge clk);
    check("hold_count", count, e.cnt);
    check("hold_winner", winner, e.win);
    check("idle_pins", pins, 0);
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    cfg_obs       = '0;
    cfg_seed      = 8'h00;
    cfg_cycles    = '0;
    cfg_stoch_log = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pins", pins, 0);
    check("reset_count", count, 0);
    check("reset_winner", winner, 0);
    rst = 1'b0;

    pat[0] = 4'b0101; pat_len = 1;
    run({9'h000, 9'h1FF, 9'h012, 9'h009}, 8'hA5, 8, 1'b1, 0, 0);

    pat[0] = 4'b1111; pat_len = 1;
    run(36'({$urandom(), $urandom()}), 8'h3C, 0, 1'b1, 0, 0);

    pat[0] = 4'b1000; pat_len = 1;
    run(36'({$urandom(), $urandom()}), 8'h81, 20, 1'b0, 0, 0);

    pat[0] = 4'b0100; pat[1] = 4'b0101; pat[2] = 4'b0110; pat[3] = 4'b0010; pat[4] = 4'b1010;
    pat_len = 5;
    run(36'({$urandom(), $urandom()}), 8'h5A, 5, 1'b1, 0, 0);

    pat[0] = 4'b0011; pat[1] = 4'b0110; pat_len = 2;
    run(36'({$urandom(), $urandom()}), 8'hC3, 10, 1'b1, 25, 1);

    pat[0] = 4'b1100; pat_len = 1;
    run(36'({$urandom(), $urandom()}), 8'h11, 2, 1'b0, 25, 1);

    pat[0] = 4'b1111; pat_len = 1;
    run(36'({$urandom(), $urandom()}), 8'h77, 6, 1'b1, 4, 2);

    pat[0] = 4'b0001; pat[1] = 4'b1000; pat[2] = 4'b1001; pat_len = 3;
    run(36'({$urandom(), $urandom()}), 8'hE2, 7, 1'b1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
